alu_secuencial: RTL and testbench
=================================

// Module: alu_secuencial
// PURPOSE
//   Sequential 4-bit arithmetic unit feeding the display stage. Captures two unsigned
//   operands and an opcode on a start pulse. Computes add, sub, multiply (shift-add)
//   or divide (restoring). Holds a signed two's-complement 9-bit result, which is
//   wired directly to the display's resultado input.
//   Slow ops are iterative (one bit per clock) to keep area small on the lab FPGA.
// PARAMETERS
//   WIDTH   4   operand width; result width is 2*WIDTH+1 (9 at default)
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst        in   1        synchronous reset, active-high
//   start      in   1        request; sampled only in IDLE
//   A          in   WIDTH    operand A, unsigned
//   B          in   WIDTH    operand B, unsigned
//   op         in   2        00 A+B, 01 A-B, 10 A*B, 11 A/B (quotient)
//   resultado  out  2*WIDTH+1  signed two's-complement result, held until next op
//   busy       out  1        high while in CALC
//   done       out  1        one-cycle pulse when resultado updates
//   err        out  1        divide-by-zero flag of last completed op
// BEHAVIOUR
//   Clock and reset
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - Reset: state=IDLE, resultado=0, busy=0, done=0, err=0, internal regs cleared.
//   - rst has priority over everything, including mid-operation; any partial
//     result is discarded.
//   State machine: IDLE -> CALC -> DONE -> IDLE
//   - IDLE: on an edge with start=1, latch A, B, op into internal regs and enter
//     CALC. Set the iteration counter to N: N=1 for op 00/01, N=WIDTH for op 10/11.
//   - CALC: busy=1. Perform one iteration per edge; after N edges enter DONE.
//   - DONE: done=1 and resultado/err hold the new values. Next edge -> IDLE.
//   - start is ignored in CALC and DONE. Operand/op changes after capture have
//     no effect.
//   Latency (E0 = edge that samples start)
//   - add/sub: done visible after E1+1 edge (2 cycles).
//   - mul/div: done after E(WIDTH)+1 (5 cycles at default).
//   - Back-to-back: start is accepted again the cycle after done.
//   Arithmetic (all results zero/sign-extended to 2*WIDTH+1)
//   - add: A+B, max 30.
//   - sub: A-B in two's complement, range -15..+15.
//   - mul: shift-add, LSB of B first; accumulator 2*WIDTH bits, max 225, sign bit 0.
//   - div: restoring division, MSB first; quotient -> resultado; remainder dropped.
//   - B=0 on div: skip iterations (go to DONE after 1 CALC cycle), resultado=0, err=1.
//   - err is updated only at DONE: cleared by any non-error op, held otherwise.
//   - resultado changes only on entry to DONE or on rst; it is stable in IDLE/CALC.
// TESTING
//   1 rst, then A=7,B=5,op=00, start 1 cycle -> done 2 cycles later, resultado=9'h00C, err=0
//   2 A=3,B=9,op=01 -> resultado=9'h1FA (-6); display shows sign and 6
//   3 A=15,B=15,op=10 -> busy 4 cycles, done at cycle 5, resultado=9'h0E1 (225)
//   4 A=13,B=4,op=11 -> resultado=3, err=0; then A=9,B=0,op=11 -> resultado=0, err=1;
//     then add 1+1 -> resultado=2, err=0
//   5 start A*B=6*7; reassert start with A=1,B=1 during busy -> ignored, resultado=42
//   6 rst at 2nd CALC cycle of 15*15 -> next cycle resultado=0, busy=0, no done pulse;
//     a new start then works normally

Source files
------------

// File: rtl/alu_secuencial.sv
// rtl/alu_secuencial.sv - sequential add/sub/shift-add multiply/restoring divide unit
module alu_secuencial #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         op,
  output logic [2*WIDTH:0]   resultado,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int RW = 2*WIDTH + 1;
  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    DONE_S = 2'b10
  } state_t;

  state_t state, state_nxt;

  // Captured operands; later changes on A/B/op are invisible to the running op
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt;

  // Multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [PW-1:0]    acc, mcand;
  logic [WIDTH-1:0] mplier;

  // Divider: partial remainder and dividend/quotient shift register
  logic [WIDTH-1:0] rem, quo;

  logic [PW-1:0]    acc_nxt;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             last, div0;
  logic [RW-1:0]    a_ext, b_ext;

  assign a_ext = RW'(a_r);
  assign b_ext = RW'(b_r);
  assign last  = (cnt == CW'(1));
  assign div0  = (op_r == OP_DIV) && (b_r == '0);

  // One iteration of shift-add multiply and restoring divide, evaluated every CALC cycle
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    shifted = {rem, quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, b_r});
    rem_nxt = fits ? WIDTH'(shifted - {1'b0, b_r}) : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (last || div0) state_nxt = DONE_S;
      end
      DONE_S: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on start, iterate in CALC, publish result on the final iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rem       <= '0;
      quo       <= '0;
      resultado <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= A;
            b_r    <= B;
            op_r   <= op;
            cnt    <= op[1] ? CW'(WIDTH) : CW'(1);
            acc    <= '0;
            mcand  <= PW'(A);
            mplier <= B;
            rem    <= '0;
            quo    <= A;
          end
        end
        CALC: begin
          cnt    <= cnt - CW'(1);
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nxt;
          quo    <= quo_nxt;
          if (div0) begin
            resultado <= '0;
            err       <= 1'b1;
          end else if (last) begin
            err <= 1'b0;
            case (op_r)
              OP_ADD:  resultado <= a_ext + b_ext;
              OP_SUB:  resultado <= a_ext - b_ext;
              OP_MUL:  resultado <= RW'(acc_nxt);
              default: resultado <= RW'(quo_nxt);
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// tb/tb_alu_secuencial.sv - scoreboard bench for alu_secuencial
module tb_alu_secuencial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic [1:0] opc;
  logic [8:0] resultado;
  logic       busy, done, err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [8:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];

  alu_secuencial #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .op(opc),
    .resultado(resultado), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && done) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: got resultado=%h err=%b, required no done pulse", resultado, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (resultado !== e.res || err !== e.err) begin
          mismatched++;
          $display("FAIL result: got resultado=%h err=%b, required resultado=%h err=%b",
                   resultado, err, e.res, e.err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [1:0] vop,
                        input logic [8:0] exp_res, input logic exp_err,
                        input int exp_busy, input bit poke);
    exp_t e;
    int busy_cyc;
    int guard;
    e.res = exp_res;
    e.err = exp_err;
    sb.push_back(e);
    a = va; b = vb; opc = vop; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    guard = 0;
    while (!done && guard < 20) begin
      if (busy) busy_cyc++;
      if (poke && busy_cyc == 1) begin
        start = 1'b1; a = 4'd1; b = 4'd1; opc = 2'b00;
      end else begin
        start = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_timeout", 9'(guard < 20), 9'd1);
    check("busy_cycles", 9'(busy_cyc), 9'(exp_busy));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; opc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_resultado", resultado, 9'h000);
    check("reset_busy", 9'(busy), 9'd0);
    check("reset_done", 9'(done), 9'd0);
    check("reset_err", 9'(err), 9'd0);

    run_op(4'd7,  4'd5,  2'b00, 9'h00C, 1'b0, 1, 1'b0);
    run_op(4'd3,  4'd9,  2'b01, 9'h1FA, 1'b0, 1, 1'b0);
    run_op(4'd15, 4'd15, 2'b10, 9'h0E1, 1'b0, 4, 1'b0);
    run_op(4'd13, 4'd4,  2'b11, 9'h003, 1'b0, 4, 1'b0);
    run_op(4'd9,  4'd0,  2'b11, 9'h000, 1'b1, 1, 1'b0);
    check("err_held_idle", 9'(err), 9'd1);
    run_op(4'd1,  4'd1,  2'b00, 9'h002, 1'b0, 1, 1'b0);
    run_op(4'd15, 4'd15, 2'b00, 9'h01E, 1'b0, 1, 1'b0);
    run_op(4'd0,  4'd15, 2'b01, 9'h1F1, 1'b0, 1, 1'b0);
    run_op(4'd15, 4'd0,  2'b01, 9'h00F, 1'b0, 1, 1'b0);
    run_op(4'd15, 4'd1,  2'b11, 9'h00F, 1'b0, 4, 1'b0);
    run_op(4'd7,  4'd15, 2'b11, 9'h000, 1'b0, 4, 1'b0);
    run_op(4'd0,  4'd9,  2'b10, 9'h000, 1'b0, 4, 1'b0);
    run_op(4'd6,  4'd7,  2'b10, 9'h02A, 1'b0, 4, 1'b1);

    // Abort a multiply in its second CALC cycle; no done pulse may follow
    a = 4'd15; b = 4'd15; opc = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_resultado", resultado, 9'h000);
    check("abort_busy", 9'(busy), 9'd0);
    check("abort_done", 9'(done), 9'd0);
    repeat (6) @(negedge clk);

    run_op(4'd2, 4'd3, 2'b10, 9'h006, 1'b0, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 9'(sb.size()), 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
